// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// clog2 sizes the address fields from the register count.
package rf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction
endpackage

// File: rtl/rf_busy_tracker.sv
// Pending-write scoreboard: one busy bit per register, issue acceptance and a
// registered count of busy registers. x0 is never marked busy.
module rf_busy_tracker
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW = clog2(NREGS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          issue_en_i,
  input  logic [AW-1:0] issue_dest_i,
  input  logic          write_en_i,
  input  logic [AW-1:0] add_dest_i,
  input  logic          flush_i,
  output logic          issue_ok_o,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]   pending_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;

  // A busy destination may still be reserved when it retires in this same cycle.
  always_comb begin
    issue_ok_o = issue_en_i && !rst_i &&
                 ((issue_dest_i == AW'(ZERO_REG)) || !busy_q[issue_dest_i] ||
                  (write_en_i && (add_dest_i == issue_dest_i)));
  end

  // Flush beats a new reservation, which beats a retiring writeback.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (write_en_i) begin
        busy_d[add_dest_i] = 1'b0;
      end
      if (issue_ok_o) begin
        busy_d[issue_dest_i] = 1'b1;
      end
    end
    busy_d[ZERO_REG] = 1'b0;
    cnt_d = '0;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o        = busy_q;
  assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/rf_scoreboard_regfile.sv
// Parametrised register file with hardwired x0, write-to-read bypass and a
// pending-write scoreboard that reports hazards back to decode.
module rf_scoreboard_regfile
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW = clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NRD*AW-1:0] Rd_Add,
  output logic [NRD*XLEN-1:0] Rd_Data,
  output logic [NRD-1:0]    Rd_Busy,
  input  logic              Write_En,
  input  logic [AW-1:0]     Add_Dest,
  input  logic [XLEN-1:0]   Write_Data,
  input  logic              Issue_En,
  input  logic [AW-1:0]     Issue_Dest,
  output logic              Issue_Ok,
  input  logic              Flush,
  output logic [AW:0]       Pending_Cnt
);

  if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("rf_scoreboard_regfile: NREGS must be a power of two >= 2");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("rf_scoreboard_regfile: NRD must be in 1..4");
  end

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0]    rd_addr [NRD];

  rf_busy_tracker #(.NREGS(NREGS)) u_busy (
    .clk_i         (CLK),
    .rst_i         (RST),
    .issue_en_i    (Issue_En),
    .issue_dest_i  (Issue_Dest),
    .write_en_i    (Write_En),
    .add_dest_i    (Add_Dest),
    .flush_i       (Flush),
    .issue_ok_o    (Issue_Ok),
    .busy_o        (busy),
    .pending_cnt_o (Pending_Cnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else if (Write_En && (Add_Dest != AW'(ZERO_REG))) begin
      regs_q[Add_Dest] <= Write_Data;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd_addr
    assign rd_addr[i] = Rd_Add[i*AW +: AW];
  end

  // Forwarded data is by definition no longer pending, so it reads as not busy.
  always_comb begin
    Rd_Data = '0;
    Rd_Busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!RST && (rd_addr[i] != AW'(ZERO_REG))) begin
        if ((BYPASS != 0) && Write_En && (Add_Dest == rd_addr[i])) begin
          Rd_Data[i*XLEN +: XLEN] = Write_Data;
        end else begin
          Rd_Data[i*XLEN +: XLEN] = regs_q[rd_addr[i]];
          Rd_Busy[i]              = busy[rd_addr[i]];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_scoreboard_regfile.sv
// Directed bench for rf_scoreboard_regfile: a bypassing and a non-bypassing
// instance share stimulus and are compared each cycle against a register/busy model.
module tb_rf_scoreboard_regfile;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [9:0]  rd_add = '0;
  logic        we = 1'b0;
  logic [4:0]  ad = '0;
  logic [31:0] wd = '0;
  logic        ie = 1'b0;
  logic [4:0]  id = '0;
  logic        flush = 1'b0;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        issue_ok_b, issue_ok_n;
  logic [5:0]  pend_b, pend_n;

  int tests_run = 0;
  int failed = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  rf_scoreboard_regfile #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_dut_byp (
    .CLK(CLK), .RST(RST), .Rd_Add(rd_add), .Rd_Data(rd_data_b), .Rd_Busy(rd_busy_b),
    .Write_En(we), .Add_Dest(ad), .Write_Data(wd), .Issue_En(ie), .Issue_Dest(id),
    .Issue_Ok(issue_ok_b), .Flush(flush), .Pending_Cnt(pend_b)
  );

  rf_scoreboard_regfile #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_dut_nobyp (
    .CLK(CLK), .RST(RST), .Rd_Add(rd_add), .Rd_Data(rd_data_n), .Rd_Busy(rd_busy_n),
    .Write_En(we), .Add_Dest(ad), .Write_Data(wd), .Issue_En(ie), .Issue_Dest(id),
    .Issue_Ok(issue_ok_n), .Flush(flush), .Pending_Cnt(pend_n)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic bit m_issue_ok();
    return ie && !RST && ((id == 5'd0) || !m_busy[id] || (we && (ad == id)));
  endfunction

  function automatic int m_pending();
    int n;
    n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic logic [31:0] m_data(input int p, input bit byp);
    logic [4:0] a;
    a = rd_add[p*5 +: 5];
    if (RST || a == 5'd0) return 32'd0;
    if (byp && we && ad == a) return wd;
    return m_regs[a];
  endfunction

  function automatic bit m_rbusy(input int p, input bit byp);
    logic [4:0] a;
    a = rd_add[p*5 +: 5];
    if (RST || a == 5'd0) return 1'b0;
    if (byp && we && ad == a) return 1'b0;
    return m_busy[a];
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < 32; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      bit acc;
      acc = m_issue_ok();
      if (we && ad != 5'd0) m_regs[ad] = wd;
      for (int r = 1; r < 32; r++) begin
        if (flush) m_busy[r] = 1'b0;
        else if (acc && id == r) m_busy[r] = 1'b1;
        else if (we && ad == r) m_busy[r] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    for (int p = 0; p < 2; p++) begin
      check($sformatf("model rd_data byp[%0d]", p), 64'(rd_data_b[p*32 +: 32]), 64'(m_data(p, 1'b1)));
      check($sformatf("model rd_data nobyp[%0d]", p), 64'(rd_data_n[p*32 +: 32]), 64'(m_data(p, 1'b0)));
      check($sformatf("model rd_busy byp[%0d]", p), 64'(rd_busy_b[p]), 64'(m_rbusy(p, 1'b1)));
      check($sformatf("model rd_busy nobyp[%0d]", p), 64'(rd_busy_n[p]), 64'(m_rbusy(p, 1'b0)));
    end
    check("model issue_ok byp", 64'(issue_ok_b), 64'(m_issue_ok()));
    check("model issue_ok nobyp", 64'(issue_ok_n), 64'(m_issue_ok()));
    check("model pending byp", 64'(pend_b), 64'(m_pending()));
    check("model pending nobyp", 64'(pend_n), 64'(m_pending()));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; ie = 1'b0; flush = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(negedge CLK);
    check("reset pending", 64'(pend_b), 64'd0);
    check("reset rd_data", rd_data_b, 64'd0);
    step(); step();
    RST = 1'b0;

    // Test 1: basic writes and two-port reads
    we = 1'b1; ad = 5'd1; wd = 32'd20;
    step(); ad = 5'd2; wd = 32'd25;
    step(); ad = 5'd3; wd = 32'd5;
    step(); idle(); rd_add = {5'd3, 5'd1};
    @(negedge CLK);
    check("read {3,1}", rd_data_b, {32'd5, 32'd20});
    step(); rd_add = {5'd2, 5'd0};
    @(negedge CLK);
    check("read {2,0}", rd_data_n, {32'd25, 32'd0});

    // Test 2: x0 hardwired
    step(); we = 1'b1; ad = 5'd0; wd = 32'd30; rd_add = '0;
    @(negedge CLK);
    check("x0 bypass read", rd_data_b, 64'd0);
    step(); idle(); ie = 1'b1; id = 5'd0;
    @(negedge CLK);
    check("x0 read after write", rd_data_b, 64'd0);
    check("issue x0 ok", 64'(issue_ok_b), 64'd1);
    step(); idle();
    @(negedge CLK);
    check("issue x0 pending", 64'(pend_b), 64'd0);

    // Test 3: bypass versus stored value
    step(); we = 1'b1; ad = 5'd7; wd = 32'd4; rd_add = {5'd0, 5'd7};
    @(negedge CLK);
    check("bypass x7", 64'(rd_data_b[31:0]), 64'd4);
    check("no bypass x7", 64'(rd_data_n[31:0]), 64'd0);
    step(); idle();
    @(negedge CLK);
    check("no bypass x7 next", 64'(rd_data_n[31:0]), 64'd4);

    // Test 4: reserve x5, reject re-issue, retire with simultaneous re-issue
    step(); ie = 1'b1; id = 5'd5; rd_add = {5'd0, 5'd5};
    @(negedge CLK);
    check("issue x5 ok", 64'(issue_ok_b), 64'd1);
    step();
    @(negedge CLK);
    check("x5 pending", 64'(pend_b), 64'd1);
    check("x5 busy", 64'(rd_busy_b[0]), 64'd1);
    check("reissue x5 rejected", 64'(issue_ok_b), 64'd0);
    step(); we = 1'b1; ad = 5'd5; wd = 32'd9;
    @(negedge CLK);
    check("retire+issue x5 ok", 64'(issue_ok_b), 64'd1);
    check("bypass x5 busy", 64'(rd_busy_b[0]), 64'd0);
    check("nobyp x5 busy", 64'(rd_busy_n[0]), 64'd1);
    step(); idle();
    @(negedge CLK);
    check("x5 still busy", 64'(rd_busy_b[0]), 64'd1);
    check("x5 data", 64'(rd_data_n[31:0]), 64'd9);

    // Test 5: three reservations, then flush beats issue
    step(); we = 1'b1; ad = 5'd5; wd = 32'd9;
    step(); idle(); ie = 1'b1; id = 5'd3;
    step(); id = 5'd4;
    step(); id = 5'd6;
    step(); idle();
    @(negedge CLK);
    check("three pending", 64'(pend_b), 64'd3);
    step(); flush = 1'b1; ie = 1'b1; id = 5'd8; rd_add = {5'd8, 5'd3};
    step(); idle();
    @(negedge CLK);
    check("flush pending", 64'(pend_n), 64'd0);
    check("flush x8 busy", 64'(rd_busy_n), 64'd0);
    check("flush data kept", rd_data_n, {32'd0, 32'd5});

    // Test 6: asynchronous reset during a write with busy bits set
    step(); ie = 1'b1; id = 5'd2;
    step(); id = 5'd4;
    step(); idle(); we = 1'b1; ad = 5'd2; wd = 32'd77; rd_add = {5'd2, 5'd2};
    @(negedge CLK);
    check("pre-reset pending", 64'(pend_b), 64'd2);
    check("pre-reset bypass", rd_data_b, {32'd77, 32'd77});
    #2;
    RST = 1'b1; ie = 1'b1; id = 5'd9;
    #1;
    check("async rst rd_data", rd_data_b, 64'd0);
    check("async rst rd_busy", 64'(rd_busy_n), 64'd0);
    check("async rst pending", 64'(pend_n), 64'd0);
    check("async rst issue_ok", 64'(issue_ok_b), 64'd0);
    step(); RST = 1'b0; idle();
    @(negedge CLK);
    check("x2 after reset", rd_data_n, 64'd0);
    check("pending after reset", 64'(pend_b), 64'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
